// File: rtl/fing_synchronizer_hga.sv
// CDC technique demonstrator: transfers uio_in to uo_out through a run-time selected
// crossing scheme (direct, raw clk_2 capture, multi-flop cascade, strobe synchronizer).
module fing_synchronizer_hga #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [2:0] SEL_DIRECT  = 3'd0;
    localparam logic [2:0] SEL_CLK2    = 3'd1;
    localparam logic [2:0] SEL_CASCADE = 3'd2;
    localparam logic [2:0] SEL_STROBE  = 3'd4;

    logic [2:0] sel;
    logic       clk_2;
    logic       stb;

    assign clk_2 = ui_in[0];
    assign sel   = ui_in[3:1];
    assign stb   = ui_in[4];

    logic                        c2_q;
    logic                        c2_d;
    logic [SYNC_STAGES-1:0][7:0] dsync;
    logic [SYNC_STAGES-1:0]      ssync;
    logic                        ssync_d;
    logic [7:0]                  out_q;
    logic [7:0]                  out_next;
    logic                        c2_rise;
    logic                        stb_pulse;

    assign c2_rise   = c2_q & ~c2_d;
    assign stb_pulse = ssync[SYNC_STAGES-1] & ~ssync_d;

    // NOTE: out_next gets its hold value first so every path assigns it and no latch is inferred.
    always_comb begin
        out_next = out_q;
        case (sel)
            SEL_DIRECT:  out_next = uio_in;
            SEL_CLK2:    if (c2_rise) out_next = uio_in;
            SEL_CASCADE: out_next = dsync[SYNC_STAGES-1];
            SEL_STROBE:  if (stb_pulse) out_next = uio_in;
            default:     out_next = out_q;
        endcase
    end

    // Helper chains advance every enabled cycle regardless of sel, so a mode change never restarts them.
    // NOTE: the synchronizer chains are cleared on reset like any other register; a stale level
    // left in them would otherwise fire a spurious strobe or cascade value after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            c2_q    <= 1'b0;
            c2_d    <= 1'b0;
            dsync   <= '0;
            ssync   <= '0;
            ssync_d <= 1'b0;
            out_q   <= 8'h00;
        end else if (ena) begin
            c2_q    <= clk_2;
            c2_d    <= c2_q;
            dsync   <= {dsync[SYNC_STAGES-2:0], uio_in};
            ssync   <= {ssync[SYNC_STAGES-2:0], stb};
            ssync_d <= ssync[SYNC_STAGES-1];
            out_q   <= out_next;
        end
    end

    assign uo_out  = out_q;
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    logic unused;
    assign unused = &{1'b0, ui_in[7:5], 1'b0};

endmodule

// File: tb/tb_fing_synchronizer_hga.sv
// Bench for fing_synchronizer_hga: directed steps plus random traffic, compared against
// an input-history reference model.
module tb_fing_synchronizer_hga;

    localparam int S = 2;

    logic       clk;
    logic       rst;
    logic       ena;
    logic       clk_2;
    logic       stb;
    logic [2:0] sel;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int errors = 0;
    int checks = 0;

    assign ui_in = {3'b000, stb, sel, clk_2};

    fing_synchronizer_hga #(.SYNC_STAGES(S)) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Source clock, 20 ns period, phase-shifted so its edges never coincide with clk edges.
    initial begin
        clk_2 = 1'b0;
        #3;
        forever #10 clk_2 = ~clk_2;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time=%0t expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    // Reference model: keeps the history of inputs seen at each enabled edge since reset,
    // and derives the output from the age of the relevant samples.
    logic [7:0] uio_h[$];
    bit         c2_h[$];
    bit         stb_h[$];
    logic [7:0] exp_out;
    int         e_idx;

    function automatic logic [7:0] uio_at(int k);
        return (k >= 0) ? uio_h[k] : 8'h00;
    endfunction

    function automatic bit c2_at(int k);
        return (k >= 0) ? c2_h[k] : 1'b0;
    endfunction

    function automatic bit stb_at(int k);
        return (k >= 0) ? stb_h[k] : 1'b0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            uio_h.delete();
            c2_h.delete();
            stb_h.delete();
            exp_out = 8'h00;
        end else if (ena) begin
            uio_h.push_back(uio_in);
            c2_h.push_back(clk_2);
            stb_h.push_back(stb);
            e_idx = uio_h.size() - 1;
            case (sel)
                3'd0: exp_out = uio_h[e_idx];
                3'd1: if (c2_at(e_idx - 1) && !c2_at(e_idx - 2)) exp_out = uio_h[e_idx];
                3'd2: exp_out = uio_at(e_idx - S);
                3'd4: if (stb_at(e_idx - S) && !stb_at(e_idx - S - 1)) exp_out = uio_h[e_idx];
                default: ;
            endcase
        end
    end

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One clk edge, then compare every output against the model.
    task automatic step(input string tag);
        @(posedge clk);
        #1;
        check(tag, uo_out, exp_out);
        check({tag, "_uio_out"}, uio_out, 8'h00);
        check({tag, "_uio_oe"}, uio_oe, 8'h00);
    endtask

    initial begin
        rst    = 1'b1;
        ena    = 1'b1;
        stb    = 1'b0;
        sel    = 3'd0;
        uio_in = 8'hA5;

        // Reset, then direct mode
        step("rst0");
        check("rst0_const", uo_out, 8'h00);
        step("rst1");
        check("rst1_const", uo_out, 8'h00);
        rst = 1'b0;
        step("rel");
        check("rel_const", uo_out, 8'hA5);
        uio_in = 8'h55;
        step("d55");
        check("d55_const", uo_out, 8'h55);
        uio_in = 8'h3C;
        step("d3c");
        check("d3c_const", uo_out, 8'h3C);

        // Raw capture on clk_2 rises
        sel = 3'd1;
        uio_in = 8'h81;
        step("c2_a");
        uio_in = 8'hFF;
        for (int i = 0; i < 4; i++) step("c2_b");
        check("c2_ff_const", uo_out, 8'hFF);
        uio_in = 8'h18;
        step("c2_c");
        uio_in = 8'hE7;
        for (int i = 0; i < 3; i++) step("c2_d");

        // Cascade: 0xFF then 0x00 arrives SYNC_STAGES+1 edges later
        sel = 3'd2;
        uio_in = 8'hFF;
        for (int i = 0; i < 4; i++) step("cas_fill");
        check("cas_ff_const", uo_out, 8'hFF);
        uio_in = 8'h00;
        step("cas_e1");
        check("cas_e1_const", uo_out, 8'hFF);
        step("cas_e2");
        check("cas_e2_const", uo_out, 8'hFF);
        step("cas_e3");
        check("cas_e3_const", uo_out, 8'h00);

        // Strobe synchronizer: one load per stb rise
        sel = 3'd4;
        uio_in = 8'hFF;
        step("stb_idle0");
        step("stb_idle1");
        stb = 1'b1;
        step("stb_k");
        check("stb_k_const", uo_out, 8'h00);
        step("stb_k1");
        check("stb_k1_const", uo_out, 8'h00);
        stb = 1'b0;
        step("stb_k2");
        check("stb_k2_const", uo_out, 8'hFF);
        uio_in = 8'h12;
        for (int i = 0; i < 4; i++) step("stb_nostb");
        check("stb_hold_const", uo_out, 8'hFF);
        stb = 1'b1;
        for (int i = 0; i < 5; i++) step("stb_long");
        check("stb_long_const", uo_out, 8'h12);
        uio_in = 8'h34;
        for (int i = 0; i < 3; i++) step("stb_long_hold");
        check("stb_once_const", uo_out, 8'h12);
        stb = 1'b0;
        step("stb_low");

        // Hold modes
        sel = 3'd3;
        uio_in = 8'h0F;
        step("sel3_a");
        uio_in = 8'hF0;
        step("sel3_b");
        check("sel3_const", uo_out, 8'h12);
        sel = 3'd5;
        uio_in = 8'hAA;
        step("sel5_a");
        uio_in = 8'h55;
        step("sel5_b");
        check("sel5_const", uo_out, 8'h12);

        // Freeze under direct mode
        sel = 3'd0;
        ena = 1'b0;
        uio_in = 8'h77;
        step("ena0_a");
        uio_in = 8'h88;
        step("ena0_b");
        check("ena0_const", uo_out, 8'h12);
        ena = 1'b1;
        uio_in = 8'h77;
        step("ena1");
        check("ena1_const", uo_out, 8'h77);

        // Strobe consumed while another mode is selected
        sel = 3'd3;
        uio_in = 8'h99;
        stb = 1'b1;
        for (int i = 0; i < 3; i++) step("stb_other_hi");
        stb = 1'b0;
        for (int i = 0; i < 3; i++) step("stb_other_lo");
        sel = 3'd4;
        for (int i = 0; i < 3; i++) step("stb_resel");
        check("stb_resel_const", uo_out, 8'h77);

        // Strobe edges during a freeze are forgotten
        ena = 1'b0;
        stb = 1'b1;
        step("frz_hi0");
        step("frz_hi1");
        stb = 1'b0;
        step("frz_lo");
        ena = 1'b1;
        for (int i = 0; i < 4; i++) step("frz_after");
        check("frz_const", uo_out, 8'h77);

        // Reset with stb held high: one load SYNC_STAGES edges after release
        stb = 1'b1;
        rst = 1'b1;
        step("rst_stb");
        check("rst_stb_const", uo_out, 8'h00);
        rst = 1'b0;
        uio_in = 8'h5A;
        step("rst_stb_k");
        check("rst_stb_k_const", uo_out, 8'h00);
        step("rst_stb_k1");
        check("rst_stb_k1_const", uo_out, 8'h00);
        step("rst_stb_k2");
        check("rst_stb_k2_const", uo_out, 8'h5A);
        stb = 1'b0;
        step("rst_stb_lo");

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            uio_in = 8'($urandom);
            if ($urandom_range(0, 7) == 0) sel = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) stb = ~stb;
            ena = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 99) == 0);
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fing_synchronizer_hga.md
Name: fing_synchronizer_hga

Overview:
- Tiny-Tapeout-style demonstrator that moves an 8-bit bus (uio_in) to uo_out using one of several clock-domain-crossing techniques, chosen at run time by a 3-bit select.
- Single clock domain (clk).
- The "source clock" clk_2 (ui_in[0]) and the strobe stb (ui_in[4]) are asynchronous inputs, sampled and edge-detected inside the clk domain.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in each synchronizer chain (data chain and strobe chain); legal values are 2 or more.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  reset, synchronous, active-high
- ena  input  1  design-selected flag; when 0, every register holds its value (reset still applies)
- ui_in  input  8  [0]=clk_2 async source clock, [3:1]=sel[2:0], [4]=stb async load strobe, [7:5] unused
- uio_in  input  8  data bus to be transferred
- uo_out  output  8  registered transferred data
- uio_out  output  8  tied to 0x00
- uio_oe  output  8  tied to 0x00, so all uio pins are inputs

Behaviour:
- Reset: when rst=1 at a clk edge, all internal registers and uo_out become 0x00. Reset takes priority over ena.
- uo_out is driven directly from a single 8-bit output register, out_q. There is no combinational path from any input to uo_out.
- Helper logic runs every enabled cycle regardless of sel, so a sel change never restarts it:
  - c2_q, c2_d: two-flop sampler of ui_in[0]. No metastability protection is intended. c2_rise = c2_q & ~c2_d.
  - dsync[0..SYNC_STAGES-1]: data chain. dsync[0] <= uio_in; dsync[i] <= dsync[i-1].
  - ssync[0..SYNC_STAGES-1]: strobe chain fed by ui_in[4], plus ssync_d <= ssync[last]. stb_pulse = ssync[last] & ~ssync_d.
- out_q next value by sel = ui_in[3:1]:
  - 0 (direct register): out_q <= uio_in every cycle. Latency 1 clk.
  - 1 (unsynchronized capture on clk_2): if c2_rise, out_q <= uio_in; otherwise hold.
  - 2 (multi-flop cascade): out_q <= dsync[last]. Latency from uio_in to uo_out is SYNC_STAGES+1 clk.
  - 4 (strobe/control synchronizer, mux recirculation): if stb_pulse, out_q <= uio_in; otherwise hold. Exactly one load per stb rising edge, however long stb stays high. stb high first sampled at edge k gives the load at edge k+SYNC_STAGES.
  - 3, 5, 6, 7: out_q holds.
- Switching sel takes effect on the next clk edge. out_q keeps its last value until the new mode writes it.
- stb asserted while sel != 4: the pulse is consumed and no load occurs. Re-selecting 4 later loads nothing until a new stb rising edge.
- Reset mid-operation clears all chains. A stb already high when rst releases produces one pulse after SYNC_STAGES edges. This is acceptable and documented.
- ena=0: all registers freeze, including the chains. Edges of clk_2 or stb occurring during the freeze are not remembered.

Test Plan:
- Common setup: clk period 10 ns; clk_2 period 20 ns.
- Reset: rst=1 for 2 cycles with uio_in=0xA5 and sel=0 -> uo_out=0x00. Release rst with ena=1 -> uo_out=0xA5 one clk later.
- sel=0: uio_in 0x55 then 0x3C on consecutive cycles -> uo_out follows with exactly 1-cycle latency.
- sel=1: uio_in=0xFF changed mid clk_2 period -> uo_out updates to 0xFF only on the cycle after a detected clk_2 rise, never between rises.
- sel=2: uio_in 0xFF -> 0x00 -> uo_out becomes 0x00 exactly 3 clk edges later (SYNC_STAGES=2) and holds 0xFF before that.
- sel=4: uio_in=0xFF, stb high for 20 ns then low -> a single load; uo_out=0xFF 2 edges after stb is first sampled high. Then uio_in=0x12 with no stb -> uo_out stays 0xFF.
- sel=3/5, ena=0 and unused outputs: uio_in toggled -> uo_out holds. With ena=0 under sel=0, uo_out holds. uio_oe=0x00 and uio_out=0x00 at all times.
